// File: rtl/pc_unit_ras.sv
// Program-counter unit with a circular return-address stack.
// Each cycle picks the next fetch address from seq, branch, jump, call or return.
module pc_unit_ras #(
    parameter int                ADDR_W      = 16,
    parameter int                RAS_DEPTH   = 4,
    parameter logic [ADDR_W-1:0] RESET_VEC   = '0,
    parameter int                INSTR_BYTES = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              stall,
    input  logic              flag_branch,
    input  logic              aluZero,
    input  logic [ADDR_W-1:0] branch_off,
    input  logic              flag_jump,
    input  logic              flag_call,
    input  logic              flag_ret,
    input  logic [ADDR_W-1:0] jump_target,
    output logic [ADDR_W-1:0] pc,
    output logic              ras_empty,
    output logic              ras_full,
    output logic              ras_overflow,
    output logic              ras_underflow,
    output logic              misalign
);

    localparam int                PTR_W     = $clog2(RAS_DEPTH);
    localparam logic [ADDR_W-1:0] INC       = ADDR_W'(INSTR_BYTES);
    localparam logic [ADDR_W-1:0] LOW_MASK  = ADDR_W'(INSTR_BYTES - 1);
    localparam logic [PTR_W:0]    DEPTH_CNT = (PTR_W + 1)'(RAS_DEPTH);

    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic [PTR_W-1:0]  top_reg, top_next;
    logic [PTR_W:0]    count_reg, count_next;
    logic              overflow_reg, overflow_next;
    logic              underflow_reg, underflow_next;
    logic              misalign_reg, misalign_next;

    logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];

    logic [ADDR_W-1:0] seq;
    logic [ADDR_W-1:0] target;
    logic              use_target;
    logic              push;
    logic              is_empty;
    logic              is_full;

    assign seq      = pc_reg + INC;
    assign is_empty = (count_reg == '0);
    assign is_full  = (count_reg == DEPTH_CNT);

    always_comb begin
        pc_next        = pc_reg;
        top_next       = top_reg;
        count_next     = count_reg;
        overflow_next  = overflow_reg;
        underflow_next = 1'b0;
        misalign_next  = 1'b0;
        target         = seq;
        use_target     = 1'b0;
        push           = 1'b0;

        if (!stall) begin
            pc_next = seq;
            if (flag_ret) begin
                if (is_empty) begin
                    underflow_next = 1'b1;
                end else begin
                    target     = ras_mem[top_reg - 1'b1];
                    use_target = 1'b1;
                    top_next   = top_reg - 1'b1;
                    count_next = count_reg - 1'b1;
                end
            end else if (flag_call) begin
                target     = jump_target;
                use_target = 1'b1;
                push       = 1'b1;
                top_next   = top_reg + 1'b1;
                // When full the write lands on the oldest slot, so depth stays saturated.
                if (is_full) begin
                    overflow_next = 1'b1;
                end else begin
                    count_next = count_reg + 1'b1;
                end
            end else if (flag_jump) begin
                target     = jump_target;
                use_target = 1'b1;
            end else if (flag_branch && aluZero) begin
                target     = seq + branch_off;
                use_target = 1'b1;
            end

            if (use_target) begin
                pc_next       = target & ~LOW_MASK;
                misalign_next = |(target & LOW_MASK);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_reg        <= RESET_VEC;
            top_reg       <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
            misalign_reg  <= 1'b0;
        end else begin
            pc_reg        <= pc_next;
            top_reg       <= top_next;
            count_reg     <= count_next;
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
            misalign_reg  <= misalign_next;
        end
    end

    // Stack contents need no reset; count and pointer define validity.
    always_ff @(posedge clock) begin
        if (push && !reset) begin
            ras_mem[top_reg] <= seq;
        end
    end

    assign pc            = pc_reg;
    assign ras_empty     = is_empty;
    assign ras_full      = is_full;
    assign ras_overflow  = overflow_reg;
    assign ras_underflow = underflow_reg;
    assign misalign      = misalign_reg;

endmodule

// File: doc/pc_unit_ras.md
Name: pc_unit_ras

Overview:
Parametrised program-counter unit, successor to the single-cycle ProgramCounter. It owns the PC register and selects the next fetch address from sequential increment, conditional branch, jump, call and return. A circular return-address stack (RAS) backs call and return. A stall input freezes the PC, and wrong-path targets are flagged.

Parameters:
ADDR_W, 16, width of PC, branch offset and jump target.
RAS_DEPTH, 4, number of RAS entries (>=2, power of two).
RESET_VEC, 16'h0000, PC value after reset (ADDR_W bits, must be aligned).
INSTR_BYTES, 2, sequential increment (1, 2 or 4).

Ports:
clock  in  1  processor clock, all state on rising edge
reset  in  1  synchronous, active-high
stall  in  1  hold all state this cycle
flag_branch  in  1  conditional branch instruction
aluZero  in  1  ALU zero result; branch taken = flag_branch & aluZero
branch_off  in  ADDR_W  sign-extended, pre-shifted byte offset
flag_jump  in  1  unconditional jump to jump_target
flag_call  in  1  jump to jump_target and push return address
flag_ret  in  1  pop RAS into PC
jump_target  in  ADDR_W  fully formed jump/call address
pc  out  ADDR_W  current fetch address (registered)
ras_empty  out  1  RAS count == 0 (combinational from state)
ras_full  out  1  RAS count == RAS_DEPTH
ras_overflow  out  1  sticky; a push overwrote the oldest entry
ras_underflow  out  1  one-cycle pulse; ret on empty RAS
misalign  out  1  one-cycle pulse; selected target not INSTR_BYTES-aligned

Behaviour:
- Reset (sync, highest priority):
  - pc=RESET_VEC; RAS count=0, top pointer=0; ras_overflow=0, ras_underflow=0, misalign=0.
  - Reset asserted mid-call/ret discards that operation. RAS entry contents are don't-care.
- seq = pc + INSTR_BYTES, modulo 2^ADDR_W (wraps silently, e.g. 16'hFFFE+2 -> 16'h0000).
- Branch target = seq + branch_off, modulo 2^ADDR_W. No overflow flag.
- Next-PC priority when not stalled: flag_ret > flag_call > flag_jump > taken branch > seq. Lower-priority flags asserted in the same cycle are ignored, with no RAS side effect.
- Latency: pc updates on the edge following the cycle in which the flags are sampled. One decision per cycle, no bubbles.
- stall=1:
  - pc, RAS and ras_overflow hold.
  - misalign and ras_underflow drive 0.
  - All flags are ignored; stall is overridden by reset.
- Call:
  - pc <= jump_target; push seq.
  - If not full: write at top, top++, count++.
  - If full: circular overwrite of the oldest entry, top++ (wraps mod RAS_DEPTH), count stays RAS_DEPTH, ras_overflow <= 1 (sticky until reset).
- Ret:
  - Not empty: pc <= entry[top-1], top--, count--.
  - Empty: pc <= seq, RAS unchanged, ras_underflow=1 for that cycle.
- Pop after overflow returns the most recent entries in LIFO order. After RAS_DEPTH pops the stack reads empty; older lost entries are not recovered.
- Alignment:
  - Applies to the selected non-sequential target (branch, jump, call, RAS).
  - If target mod INSTR_BYTES != 0: low log2(INSTR_BYTES) bits forced to 0 before loading pc, and misalign pulses for one cycle.
  - INSTR_BYTES=1 never flags.
- ras_underflow and misalign are registered pulses: high in the cycle after the offending edge, low otherwise.
- Branch not taken (flag_branch=1, aluZero=0) behaves as seq.

Test Plan:
- Reset then 3 free-running cycles, RESET_VEC=0 -> pc 0000, 0002, 0004, 0006; ras_empty=1, all error flags 0.
- pc=0010, flag_branch=1, aluZero=1, branch_off=FFFC -> pc=000E. Same with aluZero=0 -> pc=0012. branch_off=0006 from pc=FFFC -> pc=0004 (wrap).
- Nested calls: at pc=0100 call 0200, then at pc=0200 call 0300, then ret, ret -> pc sequence 0200, 0300, 0202, 0102; ras_empty=1 at the end, no overflow.
- RAS_DEPTH=4, five calls with returns 0A02, 0B02, 0C02, 0D02, 0E02, then five rets -> pops 0E02, 0D02, 0C02, 0B02; ras_overflow=1 sticky; fifth ret gives pc=seq and ras_underflow pulse.
- Simultaneous flag_ret=1, flag_call=1, flag_jump=1 with RAS top=0400 -> pc=0400, no push; stall=1 for 2 cycles with flag_call=1 -> pc and RAS count unchanged.
- jump_target=0123 -> pc=0122, misalign pulses for one cycle. Reset asserted in the same cycle as a call -> pc=RESET_VEC, ras_empty=1.
